// File: rtl/decode_stage_if.sv
// Decode stage bus: instruction handshake in, writeback port, bundle out.
// master = producer/consumer side (upstream, writeback, ALU); slave = decode_stage.
interface decode_stage_if #(
   parameter int DATA_WIDTH = 31
);
   logic                  i_instr_valid;
   logic                  o_instr_ready;
   logic [31:0]           i_instr;
   logic                  i_wb_en;
   logic [4:0]            i_wb_addr;
   logic [DATA_WIDTH:0]   i_wb_data;
   logic                  o_valid;
   logic                  i_ready;
   logic [6:0]            o_opcode;
   logic [6:0]            o_funct7;
   logic [2:0]            o_funct3;
   logic [4:0]            o_rd_addr;
   logic [DATA_WIDTH:0]   o_rs1_data;
   logic [DATA_WIDTH:0]   o_rs2_data;
   logic [31:0]           o_imm;
   logic                  o_illegal;

   modport master (
      output i_instr_valid, i_instr,
      output i_wb_en, i_wb_addr, i_wb_data,
      output i_ready,
      input  o_instr_ready, o_valid,
      input  o_opcode, o_funct7, o_funct3,
      input  o_rd_addr, o_rs1_data, o_rs2_data,
      input  o_imm, o_illegal
   );

   modport slave (
      input  i_instr_valid, i_instr,
      input  i_wb_en, i_wb_addr, i_wb_data,
      input  i_ready,
      output o_instr_ready, o_valid,
      output o_opcode, o_funct7, o_funct3,
      output o_rd_addr, o_rs1_data, o_rs2_data,
      output o_imm, o_illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field split, immediate, regfile read/write, bypass.
// Ports: clk, rst (async low), clk_en, i_flush, bus (decode_stage_if.slave).
module decode_stage #(
   parameter int DATA_WIDTH = 31
) (
   input logic          clk,
   input logic          rst,
   input logic          clk_en,
   input logic          i_flush,
   decode_stage_if.slave bus
);

   typedef logic [DATA_WIDTH:0] word_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      word_t       rs1_data;
      word_t       rs2_data;
      logic [31:0] imm;
      logic        illegal;
   } id_ex_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_REG = 7'b0110011;

   logic [31:0] ins;
   logic [6:0]  op;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [4:0]  rs1a;
   logic [4:0]  rs2a;

   assign ins  = bus.i_instr;
   assign op   = ins[6:0];
   assign f7   = ins[31:25];
   assign f3   = ins[14:12];
   assign rs1a = ins[19:15];
   assign rs2a = ins[24:20];

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25],
                   ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'b0};
   assign imm_j = {{11{ins[31]}}, ins[31],
                   ins[19:12], ins[20],
                   ins[30:21], 1'b0};

   logic        legal;
   logic [31:0] imm;

   always_comb begin
      legal = 1'b1;
      imm   = '0;
      unique case (1'b1)
         op == OP_IMM: begin
            imm = imm_i;
            if (f3 == 3'b001)
               legal = (f7 == 7'h00);
            else if (f3 == 3'b101)
               legal = (f7 == 7'h00) ||
                       (f7 == 7'h20);
         end
         op == OP_LD,
         op == OP_JLR: imm = imm_i;
         op == OP_ST:  imm = imm_s;
         op == OP_BR:  imm = imm_b;
         op == OP_LUI,
         op == OP_AUI: imm = imm_u;
         op == OP_JAL: imm = imm_j;
         op == OP_REG: begin
            legal = (f7 == 7'h00) ||
                    ((f7 == 7'h20) &&
                     ((f3 == 3'b000) ||
                      (f3 == 3'b101)));
         end
         default: legal = 1'b0;
      endcase
      if (ins[1:0] != 2'b11)
         legal = 1'b0;
   end

   // Register file; entry 0 is never written.
   word_t rf [32];
   logic  wr;

   assign wr = clk_en && bus.i_wb_en &&
               (bus.i_wb_addr != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (wr) begin
         rf[bus.i_wb_addr] <= bus.i_wb_data;
      end
   end

   // Read with same-cycle writeback bypass.
   word_t rs1_val;
   word_t rs2_val;

   always_comb begin
      rs1_val = rf[rs1a];
      if (rs1a == 5'd0)
         rs1_val = '0;
      else if (bus.i_wb_en &&
               bus.i_wb_addr == rs1a)
         rs1_val = bus.i_wb_data;
   end

   always_comb begin
      rs2_val = rf[rs2a];
      if (rs2a == 5'd0)
         rs2_val = '0;
      else if (bus.i_wb_en &&
               bus.i_wb_addr == rs2a)
         rs2_val = bus.i_wb_data;
   end

   id_ex_t nxt;

   always_comb begin
      nxt          = '0;
      nxt.opcode   = legal ? op : 7'h00;
      nxt.funct7   = f7;
      nxt.funct3   = f3;
      nxt.rd       = ins[11:7];
      nxt.rs1_data = rs1_val;
      nxt.rs2_data = rs2_val;
      nxt.imm      = legal ? imm : 32'h0;
      nxt.illegal  = ~legal;
   end

   id_ex_t     q;
   logic       v;
   logic [4:0] h_rs1;
   logic [4:0] h_rs2;
   logic       rdy;
   logic       fire_in;
   logic       fire_out;
   logic       hit1;
   logic       hit2;

   assign rdy      = clk_en && !i_flush &&
                     (!v || bus.i_ready);
   assign fire_in  = bus.i_instr_valid && rdy;
   assign fire_out = v && bus.i_ready && clk_en;

   // A held bundle tracks writes to its sources.
   assign hit1 = bus.i_wb_en &&
                 (h_rs1 != 5'd0) &&
                 (bus.i_wb_addr == h_rs1);
   assign hit2 = bus.i_wb_en &&
                 (h_rs2 != 5'd0) &&
                 (bus.i_wb_addr == h_rs2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v     <= 1'b0;
         q     <= '0;
         h_rs1 <= '0;
         h_rs2 <= '0;
      end else if (clk_en) begin
         if (i_flush) begin
            v <= 1'b0;
         end else if (fire_in) begin
            v     <= 1'b1;
            q     <= nxt;
            h_rs1 <= rs1a;
            h_rs2 <= rs2a;
         end else if (fire_out) begin
            v <= 1'b0;
         end else if (v) begin
            if (hit1)
               q.rs1_data <= bus.i_wb_data;
            if (hit2)
               q.rs2_data <= bus.i_wb_data;
         end
      end
   end

   assign bus.o_instr_ready = rdy;
   assign bus.o_valid       = v;
   assign bus.o_opcode      = q.opcode;
   assign bus.o_funct7      = q.funct7;
   assign bus.o_funct3      = q.funct3;
   assign bus.o_rd_addr     = q.rd;
   assign bus.o_rs1_data    = q.rs1_data;
   assign bus.o_rs2_data    = q.rs2_data;
   assign bus.o_imm         = q.imm;
   assign bus.o_illegal     = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage.
// Stimulus pushes expected bundles; a negedge monitor pops and compares.
module tb_decode_stage;

   logic clk;
   logic rst;
   logic clk_en;
   logic i_flush;

   decode_stage_if #(.DATA_WIDTH(31)) bus ();

   decode_stage #(.DATA_WIDTH(31)) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .i_flush (i_flush),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [4:0]  rd;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        ill;
   } bun_t;

   bun_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   int   nout   = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   function automatic bun_t mk(
      input logic [6:0]  op,
      input logic [6:0]  f7,
      input logic [2:0]  f3,
      input logic [4:0]  rd,
      input logic [31:0] r1,
      input logic [31:0] r2,
      input logic [31:0] im,
      input logic        il);
      bun_t b;
      b.opcode = op;
      b.funct7 = f7;
      b.funct3 = f3;
      b.rd     = rd;
      b.rs1    = r1;
      b.rs2    = r2;
      b.imm    = im;
      b.ill    = il;
      return b;
   endfunction

   // Monitor: compare every bundle the ALU side consumes.
   always @(negedge clk) begin
      if (rst && clk_en && bus.o_valid && bus.i_ready) begin
         nout++;
         if (exp_q.size() == 0) begin
            chk("unexpected_bundle", 64'd1, 64'd0);
         end else begin
            bun_t e;
            e = exp_q.pop_front();
            chk("opcode",  64'(bus.o_opcode),   64'(e.opcode));
            chk("funct7",  64'(bus.o_funct7),   64'(e.funct7));
            chk("funct3",  64'(bus.o_funct3),   64'(e.funct3));
            chk("rd",      64'(bus.o_rd_addr),  64'(e.rd));
            chk("rs1",     64'(bus.o_rs1_data), 64'(e.rs1));
            chk("rs2",     64'(bus.o_rs2_data), 64'(e.rs2));
            chk("imm",     64'(bus.o_imm),      64'(e.imm));
            chk("illegal", 64'(bus.o_illegal),  64'(e.ill));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_instr_valid = 1'b0;
   endtask

   task automatic wb_set(input logic [4:0] a,
                         input logic [31:0] d);
      bus.i_wb_en   = 1'b1;
      bus.i_wb_addr = a;
      bus.i_wb_data = d;
   endtask

   task automatic wb_clr();
      bus.i_wb_en = 1'b0;
   endtask

   // Present an instruction until accepted (bounded), leave valid high.
   task automatic send(input logic [31:0] ins,
                       input bun_t e);
      int n;
      n = 0;
      bus.i_instr_valid = 1'b1;
      bus.i_instr       = ins;
      @(negedge clk);
      while (!bus.o_instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_instr_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         exp_q.push_back(e);
         tick();
      end
   endtask

   initial begin
      int   c0;
      int   n0;
      int   w;
      bun_t t;

      rst               = 1'b1;
      clk_en            = 1'b1;
      i_flush           = 1'b0;
      bus.i_instr_valid = 1'b0;
      bus.i_instr       = '0;
      bus.i_wb_en       = 1'b0;
      bus.i_wb_addr     = '0;
      bus.i_wb_data     = '0;
      bus.i_ready       = 1'b1;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",   64'(bus.o_valid),    64'd0);
      chk("rst_opcode",  64'(bus.o_opcode),   64'd0);
      chk("rst_imm",     64'(bus.o_imm),      64'd0);
      chk("rst_rs1",     64'(bus.o_rs1_data), 64'd0);
      chk("rst_rs2",     64'(bus.o_rs2_data), 64'd0);
      chk("rst_illegal", 64'(bus.o_illegal),  64'd0);
      tick();
      rst = 1'b1;
      tick();

      // ADDI x1,x0,-5
      send(32'hFFB00093,
           mk(7'h13, 7'h7F, 3'd0, 5'd1, 0, 0,
              32'hFFFFFFFB, 1'b0));
      // ADD x4,x3,x3 with x3 written same cycle
      wb_set(5'd3, 32'h1234);
      send(32'h00318233,
           mk(7'h33, 7'h00, 3'd0, 5'd4, 32'h1234,
              32'h1234, 0, 1'b0));
      wb_clr();
      send(32'h00318233,
           mk(7'h33, 7'h00, 3'd0, 5'd4, 32'h1234,
              32'h1234, 0, 1'b0));
      // x0 write dropped, no bypass
      wb_set(5'd0, 32'hDEAD);
      send(32'h00000033,
           mk(7'h33, 0, 0, 0, 0, 0, 0, 1'b0));
      wb_clr();
      send(32'h00000033,
           mk(7'h33, 0, 0, 0, 0, 0, 0, 1'b0));
      idle();

      wb_set(5'd5, 32'h77);
      tick();
      wb_set(5'd6, 32'h66);
      tick();
      wb_clr();

      // Stall with held ADD x4,x5,x6
      bus.i_ready = 1'b0;
      send(32'h00628233,
           mk(7'h33, 0, 0, 5'd4, 32'h77, 32'h66, 0, 1'b0));
      bus.i_instr = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_rdy",   64'(bus.o_instr_ready), 64'd0);
         chk("stall_valid", 64'(bus.o_valid),       64'd1);
         chk("stall_rs1",   64'(bus.o_rs1_data),    64'h77);
         chk("stall_rs2",   64'(bus.o_rs2_data),    64'h66);
         chk("stall_op",    64'(bus.o_opcode),      64'h33);
      end
      tick();
      idle();
      wb_set(5'd6, 32'h55);
      tick();
      wb_clr();
      t = exp_q[exp_q.size() - 1];
      t.rs2 = 32'h55;
      exp_q[exp_q.size() - 1] = t;
      @(negedge clk);
      chk("refresh_rs2", 64'(bus.o_rs2_data), 64'h55);
      chk("refresh_rs1", 64'(bus.o_rs1_data), 64'h77);
      tick();

      // Release and stream four back to back
      bus.i_ready = 1'b1;
      c0 = cyc;
      n0 = nout;
      send(32'hFFC2A403,
           mk(7'h03, 7'h7F, 3'd2, 5'd8, 32'h77, 0,
              32'hFFFFFFFC, 1'b0));
      send(32'h0061A423,
           mk(7'h23, 7'h00, 3'd2, 5'd8, 32'h1234,
              32'h55, 32'd8, 1'b0));
      send(32'hFE6188E3,
           mk(7'h63, 7'h7F, 3'd0, 5'd17, 32'h1234,
              32'h55, 32'hFFFFFFF0, 1'b0));
      send(32'hABCDE4B7,
           mk(7'h37, 7'h55, 3'd6, 5'd9, 0, 0,
              32'hABCDE000, 1'b0));
      chk("stream_cycles", 64'(cyc - c0), 64'd4);
      idle();
      tick();
      chk("stream_bundles", 64'(nout - n0), 64'd5);

      // Illegal and remaining formats
      send(32'hFFFFFFFF,
           mk(0, 7'h7F, 3'd7, 5'd31, 0, 0, 0, 1'b1));
      send(32'h2000D093,
           mk(0, 7'h10, 3'd5, 5'd1, 0, 0, 0, 1'b1));
      send(32'h4030D093,
           mk(7'h13, 7'h20, 3'd5, 5'd1, 0, 32'h1234,
              32'h403, 1'b0));
      send(32'h40001033,
           mk(0, 7'h20, 3'd1, 0, 0, 0, 0, 1'b1));
      send(32'h00000010,
           mk(0, 0, 0, 0, 0, 0, 0, 1'b1));
      send(32'hFFDFF06F,
           mk(7'h6F, 7'h7F, 3'd7, 0, 0, 0,
              32'hFFFFFFFC, 1'b0));
      send(32'h005180E7,
           mk(7'h67, 0, 0, 5'd1, 32'h1234, 32'h77,
              32'd5, 1'b0));

      // Flush with a valid bundle and a pending instruction
      bus.i_instr = 32'h00000033;
      i_flush     = 1'b1;
      @(negedge clk);
      chk("flush_rdy", 64'(bus.o_instr_ready), 64'd0);
      tick();
      chk("flush_valid", 64'(bus.o_valid), 64'd0);
      i_flush = 1'b0;
      idle();
      tick();

      // Clock enable low: nothing moves, no write
      bus.i_ready = 1'b0;
      send(32'h00628233,
           mk(7'h33, 0, 0, 5'd4, 32'h77, 32'h55, 0, 1'b0));
      clk_en            = 1'b0;
      bus.i_ready       = 1'b1;
      bus.i_instr       = 32'hFFFFFFFF;
      wb_set(5'd5, 32'h99);
      @(negedge clk);
      chk("cen_rdy", 64'(bus.o_instr_ready), 64'd0);
      @(negedge clk);
      chk("cen_valid", 64'(bus.o_valid),    64'd1);
      chk("cen_rs1",   64'(bus.o_rs1_data), 64'h77);
      tick();
      wb_clr();
      idle();
      clk_en = 1'b1;
      send(32'h00628233,
           mk(7'h33, 0, 0, 5'd4, 32'h77, 32'h55, 0, 1'b0));
      idle();
      tick();

      // Async reset while a bundle is held
      bus.i_ready = 1'b0;
      send(32'h00628233,
           mk(7'h33, 0, 0, 5'd4, 32'h77, 32'h55, 0, 1'b0));
      idle();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", 64'(bus.o_valid),    64'd0);
      chk("async_rst_rs1",   64'(bus.o_rs1_data), 64'd0);
      exp_q.delete();
      tick();
      rst         = 1'b1;
      bus.i_ready = 1'b1;
      send(32'h00628233,
           mk(7'h33, 0, 0, 5'd4, 0, 0, 0, 1'b0));
      idle();

      w = 0;
      while (exp_q.size() != 0 && w < 20) begin
         tick();
         w++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
